// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge sequencer: state encodings, state width,
// on/off constants and the state-to-output decode used by the sequencer.
package bridge_pkg;

    localparam int   STATE_W = 3;
    localparam logic ON      = 1'b1;
    localparam logic OFF     = 1'b0;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_WARN  = 3'd1,
        S_CLEAR = 3'd2,
        S_RAISE = 3'd3,
        S_OPEN  = 3'd4,
        S_LOWER = 3'd5,
        S_FAULT = 3'd7
    } state_t;

    typedef struct packed {
        logic car_barrier;
        logic alert;
        logic bridge_s;
        logic motor_up;
        logic motor_down;
        logic fault;
    } outs_t;

    // Moore decode: each state owns a fixed output pattern; the two motor
    // drives are only ever set by different states, so they cannot overlap.
    function automatic outs_t decode_outputs(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            S_WARN, S_CLEAR: begin
                o.car_barrier = ON;
                o.alert       = ON;
            end
            S_RAISE: begin
                o.car_barrier = ON;
                o.alert       = ON;
                o.motor_up    = ON;
            end
            S_OPEN: begin
                o.car_barrier = ON;
                o.bridge_s    = ON;
            end
            S_LOWER: begin
                o.car_barrier = ON;
                o.alert       = ON;
                o.motor_down  = ON;
            end
            S_FAULT: begin
                o.car_barrier = ON;
                o.alert       = ON;
                o.fault       = ON;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/car_counter.sv
// Up/down car counter, saturating at 0 and at all-ones. Simultaneous
// enter and leave pulses cancel out.
module car_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count register: step only on a lone pulse and only if not at a rail.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/bridge_sequencer.sv
// Drawbridge sequencer: warns road traffic, waits for the deck to clear,
// raises, dwells open while boats are present, lowers, and latches a fault
// on contradictory limit switches. Optional CLEAR timeout flag is built
// when BRIDGE_CLEAR_TIMEOUT_EN is defined.
module bridge_sequencer
    import bridge_pkg::*;
#(
    parameter int WARN_CYC    = 8,
    parameter int DWELL_CYC   = 16,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_carIn,
    input  logic               i_carOut,
    input  logic               i_boatClose,
    input  logic               i_boatHere,
    input  logic               i_upLimit,
    input  logic               i_downLimit,
    output logic               o_carBarrier,
    output logic               o_alert,
    output logic               o_bridge_s,
    output logic               o_motorUp,
    output logic               o_motorDown,
    output logic               o_fault,
    output logic               o_timeout,
    output logic [STATE_W-1:0] o_state,
    output logic [CNT_W-1:0]   o_carCount
);

    localparam int MAX_AB  = (WARN_CYC > DWELL_CYC) ? WARN_CYC : DWELL_CYC;
    localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    state_t           r_state;
    state_t           w_next;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_next;
    outs_t            r_outs;
    logic             w_req;
    logic             w_limit_err;
    logic [CNT_W-1:0] w_count;

    assign w_req       = i_boatClose | i_boatHere;
    assign w_limit_err = i_upLimit & i_downLimit;

    car_counter #(.CNT_W(CNT_W)) u_car_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (i_carIn),
        .i_dec   (i_carOut),
        .o_count (w_count)
    );

    // Next-state logic; a limit-switch contradiction overrides everything.
    always_comb begin
        w_next = r_state;
        if (w_limit_err && (r_state != S_FAULT)) begin
            w_next = S_FAULT;
        end else begin
            case (r_state)
                S_IDLE:  if (w_req) w_next = S_WARN;
                S_WARN:  if (r_timer == TMR_W'(WARN_CYC - 1)) w_next = S_CLEAR;
                S_CLEAR: if (w_count == '0) w_next = S_RAISE;
                S_RAISE: if (i_upLimit) w_next = S_OPEN;
                S_OPEN:  if (!w_req && (r_timer == TMR_W'(DWELL_CYC - 1))) w_next = S_LOWER;
                S_LOWER: begin
                    // A returning boat wins over finishing the descent.
                    if (w_req)            w_next = S_RAISE;
                    else if (i_downLimit) w_next = S_IDLE;
                end
                S_FAULT: w_next = S_FAULT;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Shared timer: zero on entry to a state, zero on any request in OPEN
    // (dwell restart), otherwise a saturating cycle count.
    always_comb begin
        w_timer_next = r_timer;
        if (w_next != r_state) begin
            w_timer_next = '0;
        end else if ((r_state == S_OPEN) && w_req) begin
            w_timer_next = '0;
        end else if (r_timer != '1) begin
            w_timer_next = r_timer + 1'b1;
        end
    end

    // State, timer and outputs registered together; outputs are decoded
    // from the next state so they always match the state being entered.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_outs  <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_next;
            r_outs  <= decode_outputs(w_next);
        end
    end

`ifdef BRIDGE_CLEAR_TIMEOUT_EN
    logic r_timeout;

    // Timeout flag: set after TIMEOUT_CYC cycles stuck in CLEAR, held while
    // CLEAR persists, dropped on the cycle CLEAR is left.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_timeout <= OFF;
        end else begin
            r_timeout <= (r_state == S_CLEAR) && (w_next == S_CLEAR) &&
                         (r_timeout || (r_timer == TMR_W'(TIMEOUT_CYC - 1)));
        end
    end

    assign o_timeout = r_timeout;
`else
    assign o_timeout = OFF;
`endif

    assign o_carBarrier = r_outs.car_barrier;
    assign o_alert      = r_outs.alert;
    assign o_bridge_s   = r_outs.bridge_s;
    assign o_motorUp    = r_outs.motor_up;
    assign o_motorDown  = r_outs.motor_down;
    assign o_fault      = r_outs.fault;
    assign o_state      = r_state;
    assign o_carCount   = w_count;

endmodule

// File: doc/bridge_sequencer.md
BRIDGE_SEQUENCER -- requirements
Module: bridge_sequencer

Interface
REQ-001 Parameter WARN_CYC, default 8, cycles of alert before barrier is considered closed.
REQ-002 Parameter DWELL_CYC, default 16, consecutive request-free cycles in OPEN before lowering.
REQ-003 Parameter TIMEOUT_CYC, default 64, CLEAR-state car timeout (see REQ-026).
REQ-004 Parameter CNT_W, default 4, car counter width.
REQ-005 i_clk  in  1  single clock, rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_carIn / i_carOut  in  1 each  one-cycle pulses, car entered / left bridge.
REQ-008 i_boatClose / i_boatHere  in  1 each  boat sensors; request = i_boatClose | i_boatHere.
REQ-009 i_upLimit / i_downLimit  in  1 each  deck fully raised / fully lowered limit switches.
REQ-010 o_carBarrier, o_alert, o_bridge_s  out  1 each  barrier closed, alert lamp, bridge open to boats.
REQ-011 o_motorUp / o_motorDown  out  1 each  deck motor drive.
REQ-012 o_fault  out  1  sticky fault; o_timeout  out  1  CLEAR timeout flag.
REQ-013 o_state  out  3  current state code; o_carCount  out  CNT_W  cars on bridge.

Function
REQ-014 States SHALL be IDLE=0, WARN=1, CLEAR=2, RAISE=3, OPEN=4, LOWER=5, FAULT=7; all outputs registered, decoded from state.
REQ-015 IDLE: all outputs 0; request high -> WARN next cycle.
REQ-016 WARN: o_alert=1, o_carBarrier=1; after exactly WARN_CYC cycles in WARN -> CLEAR, regardless of request dropping.
REQ-017 CLEAR: o_alert=1, o_carBarrier=1; o_carCount==0 -> RAISE next cycle.
REQ-018 RAISE: o_motorUp=1, barrier/alert 1; i_upLimit -> OPEN, motor off in OPEN's first cycle.
REQ-019 OPEN: o_bridge_s=1, o_carBarrier=1, motors 0; DWELL_CYC consecutive cycles of request low -> LOWER; any request cycle restarts dwell count.
REQ-020 LOWER: o_motorDown=1, barrier/alert 1; i_downLimit -> IDLE; request reasserted before i_downLimit -> RAISE (boat priority).
REQ-021 o_motorUp and o_motorDown SHALL never be 1 in the same cycle.
REQ-022 i_upLimit & i_downLimit both high in any state -> FAULT; FAULT: barrier=1, alert=1, fault=1, motors 0; exit only by reset.
REQ-023 Car counter: carIn only -> +1, carOut only -> -1, both or neither -> hold; saturates at 2^CNT_W-1 and 0; counts in every state.
REQ-024 Single shared cycle timer, cleared on every state change; width ceil(log2(max(WARN_CYC,DWELL_CYC,TIMEOUT_CYC)+1)).

Reset
REQ-025 i_reset low SHALL immediately force IDLE, car count 0, timer 0, all outputs 0 (motors off mid-travel), o_fault and o_timeout cleared.

Configuration
REQ-026 Macro BRIDGE_CLEAR_TIMEOUT_EN defined: in CLEAR, count nonzero for TIMEOUT_CYC cycles -> o_timeout=1 held until CLEAR is left; state unchanged.
REQ-027 Macro undefined: o_timeout tied 0, no timeout logic, CLEAR waits indefinitely.

Structure
REQ-028 Shared package bridge_pkg SHALL hold state encodings, state width and on/off constants.
REQ-029 Car counter SHALL be a sub-module car_counter (up/down, saturating, count output).

Verification
REQ-030 Reset, request high 1 cycle -> WARN, o_alert=1 for 8 cycles, CLEAR, count 0 -> RAISE, o_motorUp=1 until i_upLimit -> OPEN, o_bridge_s=1.
REQ-031 Two carIn pulses during WARN, one carOut in CLEAR -> stays CLEAR with count 1; second carOut -> RAISE next cycle.
REQ-032 OPEN, request drops 10 cycles, returns 1 cycle, drops 16 cycles -> LOWER only after final 16; i_downLimit -> IDLE, all outputs 0.
REQ-033 LOWER, request reasserts before i_downLimit -> RAISE, o_motorDown falls, o_motorUp rises, never overlapping.
REQ-034 i_upLimit=i_downLimit=1 in RAISE -> FAULT, motors 0, o_fault=1 persists until i_reset low; carIn with carOut same cycle -> count unchanged; 16 carIn at CNT_W=4 -> count 15.
REQ-035 With BRIDGE_CLEAR_TIMEOUT_EN, count 1 held in CLEAR 64 cycles -> o_timeout=1; carOut -> RAISE, o_timeout=0.
